gpa_fhdo_spi_seq: RTL and testbench

Parametrised, buffered SPI sequencer for the GPA-FHDO gradient board. It succeeds the single-word GPA-FHDO interface. It accepts 32-bit command words into an internal FIFO and serialises them to the DAC80504 and ADS8684 over a shared SCLK/SDO/SDI bus with separate chip selects. It also drives LDAC and returns ADC readback words tagged with their channel. It sits between the OCRA gradient sequencer (upstream) and the board pins (downstream).

---
 rtl/gpa_fhdo_pkg.sv | 27 ++
 rtl/gpa_fhdo_fifo.sv | 63 ++++++
 rtl/gpa_fhdo_spi_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_gpa_fhdo_spi_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpa_fhdo_pkg.sv
// Shared command codes, command-word field positions and sequencer states.
package gpa_fhdo_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ADC_W    = 16;

  localparam logic [4:0] CMD_DAC = 5'b00000;
  localparam logic [4:0] CMD_ADC = 5'b01000;

  // Command word layout: {cmd, chan, upd, payload}
  localparam int unsigned CMD_MSB  = 31;
  localparam int unsigned CMD_LSB  = 27;
  localparam int unsigned CHAN_MSB = 26;
  localparam int unsigned CHAN_LSB = 25;
  localparam int unsigned UPD_BIT  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_LDAC
  } state_t;

endpackage

// File: rtl/gpa_fhdo_fifo.sv
// Synchronous command FIFO; a pop frees a slot for a same-cycle write when full.
module gpa_fhdo_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en_c;
  logic             rd_en_c;
  logic [CW-1:0]    count_nxt_c;

  assign rd_en_c = pop && !empty;
  assign wr_en_c = push && (!full || rd_en_c);
  assign rd_data = mem[rd_ptr];

  // Next occupancy from the qualified write/read strobes
  always_comb begin
    count_nxt_c = count;
    if (wr_en_c && !rd_en_c) begin
      count_nxt_c = count + 1'b1;
    end else if (!wr_en_c && rd_en_c) begin
      count_nxt_c = count - 1'b1;
    end
  end

  // Pointers and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en_c) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gpa_fhdo_spi_seq.sv
// Buffered SPI sequencer for the GPA-FHDO DAC80504/ADS8684 bus with LDAC and ADC readback.
module gpa_fhdo_spi_seq
  import gpa_fhdo_pkg::*;
#(
  parameter int unsigned FRAME_W    = 24,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 6,
  parameter int unsigned LDAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [DIV_W-1:0]              spi_clk_div_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fhd_clk_o,
  output logic                          fhd_sdo_o,
  input  logic                          fhd_sdi_i,
  output logic                          dac_csn_o,
  output logic                          adc_csn_o,
  output logic                          ldacn_o,
  output logic [15:0]                   adc_value_o,
  output logic [1:0]                    adc_chan_o,
  output logic                          adc_valid_o,
  output logic                          overflow_o,
  output logic                          cmd_err_o
);

  localparam int unsigned BIT_W = $clog2(FRAME_W);
  localparam int unsigned LW    = $clog2(LDAC_W) + 1;

  logic [WORD_W-1:0]          fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop_c;
  logic                       push_acc_c;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [LW-1:0]      lcnt_q, lcnt_d;
  logic               sclk_q, sclk_d;
  logic               dcs_q, dcs_d;
  logic               acs_q, acs_d;
  logic               ldacn_q, ldacn_d;
  logic [ADC_W-1:0]   aval_q, aval_d;
  logic [1:0]         achan_q, achan_d;
  logic               avalid_q, avalid_d;
  logic               ovf_q, ovf_d;
  logic               cerr_q, cerr_d;
  logic               busy_q, busy_d;
  logic               half_done_c;
  logic [4:0]         cmd_c;

  gpa_fhdo_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (valid_i),
    .pop     (fifo_pop_c),
    .wr_data (data_i),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign half_done_c = (tick_q == div_q);
  assign cmd_c       = word_q[CMD_MSB:CMD_LSB];
  assign push_acc_c  = valid_i && (!fifo_full || fifo_pop_c);

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    div_d      = div_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    lcnt_d     = lcnt_q;
    sclk_d     = sclk_q;
    dcs_d      = dcs_q;
    acs_d      = acs_q;
    ldacn_d    = ldacn_q;
    aval_d     = aval_q;
    achan_d    = achan_q;
    avalid_d   = 1'b0;
    cerr_d     = cerr_q;
    fifo_pop_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          word_d     = fifo_rd_data;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        div_d  = spi_clk_div_i;
        tick_d = '0;
        bit_d  = '0;
        sclk_d = 1'b1;
        sh_d   = word_q[FRAME_W-1:0];
        if (cmd_c == CMD_DAC) begin
          dcs_d   = 1'b0;
          state_d = ST_SETUP;
        end else if (cmd_c == CMD_ADC) begin
          acs_d   = 1'b0;
          state_d = ST_SETUP;
        end else begin
          cerr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (half_done_c) begin
          tick_d  = '0;
          sclk_d  = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!half_done_c) begin
          tick_d = tick_q + 1'b1;
        end else begin
          tick_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture SDI and present the next bit on the MSB
            sclk_d = 1'b1;
            sh_d   = {sh_q[FRAME_W-2:0], fhd_sdi_i};
          end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (half_done_c) begin
          tick_d  = '0;
          dcs_d   = 1'b1;
          acs_d   = 1'b1;
          state_d = ST_GAP;
          if (cmd_c == CMD_ADC) begin
            aval_d   = sh_q[ADC_W-1:0];
            achan_d  = word_q[CHAN_MSB:CHAN_LSB];
            avalid_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (half_done_c) begin
          tick_d = '0;
          if ((cmd_c == CMD_DAC) && word_q[UPD_BIT]) begin
            ldacn_d = 1'b0;
            lcnt_d  = '0;
            state_d = ST_LDAC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_LDAC: begin
        if (lcnt_q == LW'(LDAC_W - 1)) begin
          ldacn_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d  = ovf_q | (valid_i & fifo_full & ~fifo_pop_c);
    busy_d = (state_d != ST_IDLE) || push_acc_c || !fifo_empty;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      div_q    <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      lcnt_q   <= '0;
      sclk_q   <= 1'b1;
      dcs_q    <= 1'b1;
      acs_q    <= 1'b1;
      ldacn_q  <= 1'b1;
      aval_q   <= '0;
      achan_q  <= '0;
      avalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      cerr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      lcnt_q   <= lcnt_d;
      sclk_q   <= sclk_d;
      dcs_q    <= dcs_d;
      acs_q    <= acs_d;
      ldacn_q  <= ldacn_d;
      aval_q   <= aval_d;
      achan_q  <= achan_d;
      avalid_q <= avalid_d;
      ovf_q    <= ovf_d;
      cerr_q   <= cerr_d;
      busy_q   <= busy_d;
    end
  end

  assign ready_o      = ~fifo_full;
  assign fifo_count_o = fifo_count;
  assign busy_o       = busy_q;
  assign fhd_clk_o    = sclk_q;
  assign fhd_sdo_o    = sh_q[FRAME_W-1];
  assign dac_csn_o    = dcs_q;
  assign adc_csn_o    = acs_q;
  assign ldacn_o      = ldacn_q;
  assign adc_value_o  = aval_q;
  assign adc_chan_o   = achan_q;
  assign adc_valid_o  = avalid_q;
  assign overflow_o   = ovf_q;
  assign cmd_err_o    = cerr_q;

endmodule

// File: tb/tb_gpa_fhdo_spi_seq.sv
// Bench for gpa_fhdo_spi_seq: bus-level SPI slave models and a word-level scoreboard.
module tb_gpa_fhdo_spi_seq;

  localparam int unsigned FW    = 24;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 6;
  localparam int unsigned LW    = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    data_i;
  logic           valid_i;
  logic           ready_o;
  logic [DW-1:0]  spi_clk_div_i;
  logic           busy_o;
  logic [CW-1:0]  fifo_count_o;
  logic           fhd_clk_o;
  logic           fhd_sdo_o;
  logic           fhd_sdi_i;
  logic           dac_csn_o;
  logic           adc_csn_o;
  logic           ldacn_o;
  logic [15:0]    adc_value_o;
  logic [1:0]     adc_chan_o;
  logic           adc_valid_o;
  logic           overflow_o;
  logic           cmd_err_o;

  int checks = 0;
  int fails  = 0;

  gpa_fhdo_spi_seq #(
    .FRAME_W(FW), .FIFO_DEPTH(DEPTH), .DIV_W(DW), .LDAC_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .spi_clk_div_i(spi_clk_div_i), .busy_o(busy_o), .fifo_count_o(fifo_count_o),
    .fhd_clk_o(fhd_clk_o), .fhd_sdo_o(fhd_sdo_o), .fhd_sdi_i(fhd_sdi_i),
    .dac_csn_o(dac_csn_o), .adc_csn_o(adc_csn_o), .ldacn_o(ldacn_o),
    .adc_value_o(adc_value_o), .adc_chan_o(adc_chan_o), .adc_valid_o(adc_valid_o),
    .overflow_o(overflow_o), .cmd_err_o(cmd_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Bus monitor: SPI slave that samples SDO on SCLK falling edges, ADC returns data, DAC latches on LDAC
  typedef struct {
    bit          is_adc;
    logic [FW-1:0] bits;
    int          nbits;
    int          low_cyc;
    int          gap;
  } frame_t;

  frame_t       frames[$];
  frame_t       cur;
  logic         p_dcs = 1'b1, p_acs = 1'b1, p_sclk = 1'b1, p_ldac = 1'b1;
  int           falls = 0, hi_cyc = 0, since_cs = 0, ldac_low = 0, ldac_delay = -1, adc_pulses = 0;
  int           ldac_chan = 0;
  logic [15:0]  adc_ret = '0;
  logic [15:0]  adc_seen_v = '0;
  logic [1:0]   adc_seen_c = '0;
  logic [15:0]  dac_last = '0;
  logic [15:0]  vout [4];

  always @(negedge clk) begin
    if (!rst_n) begin
      p_dcs = 1'b1; p_acs = 1'b1; p_sclk = 1'b1; p_ldac = 1'b1;
    end else begin : mon
      bit cs_low, p_low;
      cs_low = !dac_csn_o || !adc_csn_o;
      p_low  = !p_dcs || !p_acs;
      if (cs_low && !p_low) begin
        cur.is_adc = !adc_csn_o; cur.bits = '0; cur.nbits = 0; cur.low_cyc = 0; cur.gap = hi_cyc;
        falls++;
      end
      if (cs_low) begin
        cur.low_cyc++;
        if (p_sclk && !fhd_clk_o) begin
          if (cur.is_adc) fhd_sdi_i = (cur.nbits >= FW - 16) ? adc_ret[FW - 1 - cur.nbits] : 1'b0;
          cur.bits = {cur.bits[FW-2:0], fhd_sdo_o};
          cur.nbits++;
        end
      end
      if (!cs_low && p_low) begin
        frames.push_back(cur);
        if (!cur.is_adc) dac_last = cur.bits[15:0];
        since_cs = 0; hi_cyc = 1;
      end else if (!cs_low) begin
        since_cs++; hi_cyc++;
      end
      if (!ldacn_o) begin
        ldac_low++;
        if (p_ldac) begin ldac_delay = since_cs; vout[ldac_chan] = dac_last; end
      end
      if (adc_valid_o) begin adc_pulses++; adc_seen_v = adc_value_o; adc_seen_c = adc_chan_o; end
      p_dcs = dac_csn_o; p_acs = adc_csn_o; p_sclk = fhd_clk_o; p_ldac = ldacn_o;
    end
  end

  task automatic write_word(input logic [31:0] w);
    data_i = w; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int c = 0;
    while (frames.size() < n && c < budget) begin @(posedge clk); #1; c++; end
    ok = (frames.size() >= n);
    checks++;
    if (!ok) begin fails++; $display("FAIL frame_wait: got %0d frames, need %0d", frames.size(), n); end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy_o !== 1'b0 && c < 5000) begin @(posedge clk); #1; c++; end
    checks++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL idle_wait: busy_o=%b, required 0", busy_o); end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({fhd_clk_o, dac_csn_o, adc_csn_o, ldacn_o, ready_o} !== 5'b11111) begin
      fails++; $display("FAIL %s_high: got %b, required 11111", tag, {fhd_clk_o, dac_csn_o, adc_csn_o, ldacn_o, ready_o});
    end
    checks++;
    if ({fhd_sdo_o, busy_o, adc_valid_o, overflow_o, cmd_err_o, adc_value_o, adc_chan_o, fifo_count_o} !== '0) begin
      fails++; $display("FAIL %s_low: sdo/busy/valid/ovf/err=%b value=%h chan=%0d count=%0d, required all zero", tag,
                        {fhd_sdo_o, busy_o, adc_valid_o, overflow_o, cmd_err_o}, adc_value_o, adc_chan_o, fifo_count_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; spi_clk_div_i = '0; fhd_sdi_i = 1'b0;
    for (int i = 0; i < 4; i++) vout[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_dac_frame(input logic [23:0] payload, input int div, input string tag);
    bit ok;
    wait_frames(1, 4000, ok);
    if (ok) begin
      checks++;
      if (frames[0].bits !== payload || frames[0].nbits != FW || frames[0].is_adc) begin
        fails++; $display("FAIL %s_bits: got %h (%0d bits, adc=%0d), required %h on DAC", tag,
                          frames[0].bits, frames[0].nbits, frames[0].is_adc, payload);
      end
      checks++;
      if (frames[0].low_cyc != (2 * FW + 2) * (div + 1)) begin
        fails++; $display("FAIL %s_len: got %0d, required %0d", tag, frames[0].low_cyc, (2 * FW + 2) * (div + 1));
      end
    end
    wait_idle();
  endtask

  task automatic test_dac_write();
    int lat;
    logic [23:0] p;
    int d;
    frames.delete(); ldac_low = 0;
    spi_clk_div_i = '0;
    write_word({5'b00000, 2'd1, 1'b0, 24'h10ABCD});
    checks++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL busy_after_accept: got %b, required 1", busy_o); end
    lat = 0;
    while (dac_csn_o && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 2) begin fails++; $display("FAIL accept_to_csn: got %0d, required 2", lat); end
    check_dac_frame(24'h10ABCD, 0, "dac");
    checks++;
    if (ldac_low != 0 || frames.size() != 1) begin
      fails++; $display("FAIL dac_quiet: ldac_low=%0d frames=%0d, required 0 and 1", ldac_low, frames.size());
    end
    for (int i = 0; i < 3; i++) begin
      frames.delete();
      d = int'($urandom_range(0, 3));
      p = 24'($urandom);
      spi_clk_div_i = DW'(d);
      write_word({5'b00000, 2'($urandom), 1'b0, p});
      check_dac_frame(p, d, "dac_rand");
    end
  endtask

  task automatic test_ldac();
    frames.delete(); ldac_low = 0; ldac_delay = -1; ldac_chan = 1; vout[1] = '0;
    spi_clk_div_i = '0;
    write_word({5'b00000, 2'd1, 1'b1, 24'h10ABCD});
    check_dac_frame(24'h10ABCD, 0, "ldac_frame");
    checks++;
    if (ldac_low != LW || ldac_delay != 1) begin
      fails++; $display("FAIL ldac_pulse: width=%0d delay=%0d, required %0d and 1", ldac_low, ldac_delay, LW);
    end
    checks++;
    if (vout[1] !== 16'hABCD) begin fails++; $display("FAIL dac_vout1: got %h, required abcd", vout[1]); end
  endtask

  task automatic do_adc(input logic [15:0] ret, input logic [1:0] ch, input int d, input string tag);
    bit ok;
    frames.delete(); adc_pulses = 0; ldac_low = 0; adc_ret = ret;
    spi_clk_div_i = DW'(d);
    write_word({5'b01000, ch, 1'b1, 24'hC800});
    wait_frames(1, 4000, ok);
    wait_idle();
    checks++;
    if (adc_pulses != 1 || adc_seen_v !== ret || adc_seen_c !== ch) begin
      fails++; $display("FAIL %s: pulses=%0d value=%h chan=%0d, required 1 %h %0d", tag, adc_pulses, adc_seen_v, adc_seen_c, ret, ch);
    end
    if (ok) begin
      checks++;
      if (!frames[0].is_adc || frames[0].bits !== 24'hC800 || ldac_low != 0) begin
        fails++; $display("FAIL %s_frame: adc=%0d bits=%h ldac_low=%0d, required 1 00c800 0", tag,
                          frames[0].is_adc, frames[0].bits, ldac_low);
      end
    end
  endtask

  task automatic test_adc_read();
    do_adc(16'h1234, 2'd2, 0, "adc");
    for (int i = 0; i < 2; i++) do_adc(16'($urandom), 2'($urandom), int'($urandom_range(0, 2)), "adc_rand");
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc[$];
    logic [31:0] w;
    int occ, c;
    bit ok;
    frames.delete();
    spi_clk_div_i = DW'(3);
    write_word({5'b00000, 2'd0, 1'b0, 24'($urandom)});
    c = 0;
    while (dac_csn_o && c < 10) begin @(posedge clk); #1; c++; end
    occ = 0;
    for (int i = 0; i < 9; i++) begin
      w = {5'b00000, 2'($urandom), 1'b0, 24'($urandom)};
      data_i = w; valid_i = 1'b1;
      if (occ < DEPTH) begin acc.push_back(w); occ++; end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || overflow_o !== 1'b1 || fifo_count_o !== CW'(occ)) begin
      fails++; $display("FAIL burst_full: ready=%b ovf=%b count=%0d, required 0 1 %0d", ready_o, overflow_o, fifo_count_o, occ);
    end
    wait_frames(9, 3000, ok);
    if (ok) begin
      for (int i = 1; i < 9; i++) begin
        checks++;
        if (frames[i].bits !== acc[i-1][23:0] || frames[i].low_cyc != 200 || frames[i].gap != 6) begin
          fails++; $display("FAIL burst_frame%0d: bits=%h len=%0d gap=%0d, required %h 200 6", i,
                            frames[i].bits, frames[i].low_cyc, frames[i].gap, acc[i-1][23:0]);
        end
      end
    end
    wait_idle();
    checks++;
    if (frames.size() != 9) begin fails++; $display("FAIL burst_count: got %0d frames, required 9", frames.size()); end
  endtask

  task automatic test_bad_cmd();
    int f0;
    logic [23:0] p;
    frames.delete();
    spi_clk_div_i = '0;
    f0 = falls;
    write_word({5'b11111, 2'd3, 1'b1, 24'($urandom)});
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (falls != f0 || cmd_err_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL bad_cmd: csn_falls=%0d err=%b busy=%b, required 0 1 0", falls - f0, cmd_err_o, busy_o);
    end
    p = 24'($urandom);
    write_word({5'b00000, 2'd2, 1'b0, p});
    check_dac_frame(p, 0, "after_bad");
  endtask

  task automatic test_reset_mid();
    int f0, c;
    spi_clk_div_i = '0;
    f0 = falls;
    for (int i = 0; i < 3; i++) begin
      data_i = {5'b00000, 2'($urandom), 1'b0, 24'($urandom)}; valid_i = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    c = 0;
    while (falls < f0 + 2 && c < 500) begin @(posedge clk); #1; c++; end
    checks++;
    if (falls < f0 + 2) begin fails++; $display("FAIL second_frame: got %0d frames started, required 2", falls - f0); end
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    frames.delete();
    f0 = falls;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (falls != f0 || busy_o !== 1'b0 || fifo_count_o !== '0) begin
      fails++; $display("FAIL post_reset_quiet: frames=%0d busy=%b count=%0d, required 0 0 0", falls - f0, busy_o, fifo_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_dac_write();
    test_ldac();
    test_adc_read();
    test_back_to_back();
    test_bad_cmd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
